// File: rtl/serial_sub_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: one bit per clock, LSB first, through a single
// subtractor cell; result and underflow publish only when the last bit is done.
module serial_subtractor_nbit
  import serial_sub_pkg::*;
#(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 underflow
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);

  state_t               state_reg;
  logic [BIT_WIDTH-1:0] a_reg;
  logic [BIT_WIDTH-1:0] b_reg;
  logic                 borrow_reg;
  logic [BIT_WIDTH-1:0] res_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BIT_WIDTH-1:0] diff_reg;
  logic                 underflow_reg;

  logic                 cell_d;
  logic                 cell_bout;
  logic                 accept;
  logic                 last_bit;
  logic [BIT_WIDTH-1:0] res_next;

  subtractor_1bit u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // A new request is only taken when no operation is in flight.
  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (cnt_reg == CNT_W'(BIT_WIDTH - 1));
  assign res_next = {cell_d, res_reg[BIT_WIDTH-1:1]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      borrow_reg    <= 1'b0;
      res_reg       <= '0;
      cnt_reg       <= '0;
      diff_reg      <= '0;
      underflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= borrow_in;
            res_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= SUB;
          end else begin
            state_reg <= IDLE;
          end
        end
        SUB: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          borrow_reg <= cell_bout;
          res_reg    <= res_next;
          if (last_bit) begin
            diff_reg      <= res_next;
            underflow_reg <= cell_bout;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Simulation-only guard against unknown operands being captured.
  always @(posedge clk) begin
    if (n_rst && accept) begin
      assert (!$isunknown({a, b, borrow_in}))
        else $error("serial_subtractor_nbit: X/Z on operands at acceptance");
    end
  end

  assign busy      = (state_reg == SUB);
  assign done      = (state_reg == DONE);
  assign diff      = diff_reg;
  assign underflow = underflow_reg;

endmodule
